// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the HEX5/HEX4 display driver.
// Segment patterns are active-low: a 0 bit lights the segment.
package hex_disp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } disp_state_e;

  localparam logic [6:0] BLANK7 = 7'h7F;

  localparam int HEX4_LSB = 0;
  localparam int HEX4_MSB = 6;
  localparam int HEX5_LSB = 8;
  localparam int HEX5_MSB = 14;

  // Packs the two 7-bit digit fields of a PIO word, dropping bits 7 and 15.
  function automatic logic [13:0] seg_digits(input logic [15:0] seg);
    return {seg[HEX5_MSB:HEX5_LSB], seg[HEX4_MSB:HEX4_LSB]};
  endfunction

endpackage

// File: rtl/hex_pwm_prescaler.sv
// Free-running blink phase generator and 16-step PWM brightness modulator.
// Brightness is only sampled at a PWM period boundary so duty never glitches.
module hex_pwm_prescaler
  import hex_disp_pkg::*;
#(
  parameter int BLINK_HALF_CYCLES = 12_500_000,
  parameter int PWM_DIV           = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] brightness_i,
  output logic       blink_phase_o,
  output logic       pwm_on_o
);

  localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam int DIV_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [DIV_W-1:0]   pwm_div_cnt_q, pwm_div_cnt_d;
  logic [3:0]         pwm_cnt_q, pwm_cnt_d;
  logic [3:0]         bright_q, bright_d;
  logic               blink_wrap_s;
  logic               div_wrap_s;

  // Next-state for the blink and PWM counters.
  always_comb begin
    blink_wrap_s = (blink_cnt_q == BLINK_W'(BLINK_HALF_CYCLES - 1));
    div_wrap_s   = (pwm_div_cnt_q == DIV_W'(PWM_DIV - 1));

    if (blink_wrap_s) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_phase_q;
    end

    if (div_wrap_s) begin
      pwm_div_cnt_d = '0;
      pwm_cnt_d     = pwm_cnt_q + 4'd1;
    end else begin
      pwm_div_cnt_d = pwm_div_cnt_q + DIV_W'(1);
      pwm_cnt_d     = pwm_cnt_q;
    end

    if (div_wrap_s && (pwm_cnt_q == 4'd15)) begin
      bright_d = brightness_i;
    end else begin
      bright_d = bright_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pwm_div_cnt_q <= '0;
      pwm_cnt_q     <= 4'd0;
      bright_q      <= 4'd0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_div_cnt_q <= pwm_div_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      bright_q      <= bright_d;
    end
  end

  assign blink_phase_o = blink_phase_q;
  assign pwm_on_o      = (bright_q == 4'd15) | (pwm_cnt_q < bright_q);

endmodule

// File: rtl/hex_pair_display_driver.sv
// Drives HEX4/HEX5 from the PIO pattern with per-digit blink, PWM brightness
// and a steady full-brightness hold after every pattern change.
module hex_pair_display_driver
  import hex_disp_pkg::*;
#(
  parameter int BLINK_HALF_CYCLES = 12_500_000,
  parameter int PWM_DIV           = 64,
  parameter int HOLD_CYCLES       = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] seg_in,
  input  logic [1:0]  blink_en,
  input  logic [3:0]  brightness,
  output logic [6:0]  hex4_n,
  output logic [6:0]  hex5_n,
  output logic        update_pulse,
  output logic        holding
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [15:0]       seg_q;
  logic              update_pulse_q;
  disp_state_e       state_q, state_d;
  logic              holding_q;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [6:0]        hex4_q, hex4_d;
  logic [6:0]        hex5_q, hex5_d;
  logic              change_s;
  logic              vis4_s;
  logic              vis5_s;
  logic              blink_phase_s;
  logic              pwm_on_s;
  logic              unused_s;

  hex_pwm_prescaler #(
    .BLINK_HALF_CYCLES(BLINK_HALF_CYCLES),
    .PWM_DIV          (PWM_DIV)
  ) u_prescaler (
    .clk          (clk),
    .reset_n      (reset_n),
    .brightness_i (brightness),
    .blink_phase_o(blink_phase_s),
    .pwm_on_o     (pwm_on_s)
  );

  // Change detect, hold FSM and per-digit visibility.
  always_comb begin
    change_s   = (seg_digits(seg_in) != seg_digits(seg_q));
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (change_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end else begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        // A new pattern while holding restarts the steady period.
        if (change_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          state_d    = ST_HOLD;
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase

    vis4_s = (state_q == ST_HOLD) | (pwm_on_s & ~(blink_en[0] & blink_phase_s));
    vis5_s = (state_q == ST_HOLD) | (pwm_on_s & ~(blink_en[1] & blink_phase_s));

    if (vis4_s) begin
      hex4_d = seg_q[HEX4_MSB:HEX4_LSB];
    end else begin
      hex4_d = BLANK7;
    end

    if (vis5_s) begin
      hex5_d = seg_q[HEX5_MSB:HEX5_LSB];
    end else begin
      hex5_d = BLANK7;
    end
  end

  // Pattern capture, FSM state and output pin registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q          <= 16'hFFFF;
      update_pulse_q <= 1'b0;
      state_q        <= ST_IDLE;
      holding_q      <= 1'b0;
      hold_cnt_q     <= '0;
      hex4_q         <= BLANK7;
      hex5_q         <= BLANK7;
    end else begin
      seg_q          <= seg_in;
      update_pulse_q <= change_s;
      state_q        <= state_d;
      holding_q      <= (state_d == ST_HOLD);
      hold_cnt_q     <= hold_cnt_d;
      hex4_q         <= hex4_d;
      hex5_q         <= hex5_d;
    end
  end

  // Bits 7 and 15 of the PIO word have no segment behind them.
  assign unused_s = seg_q[15] ^ seg_q[7];

  assign hex4_n       = hex4_q;
  assign hex5_n       = hex5_q;
  assign update_pulse = update_pulse_q;
  assign holding      = holding_q;

endmodule

// File: tb/tb_hex_pair_display_driver.sv
// Scoreboard bench for hex_pair_display_driver with small timing parameters.
// Expected pins come from a cycle-count based reference model.
module tb_hex_pair_display_driver;

  localparam int BLINK  = 8;
  localparam int PWMD   = 2;
  localparam int HOLD   = 20;
  localparam int PERIOD = 16 * PWMD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] seg_in;
  logic [1:0]  blink_en;
  logic [3:0]  brightness;
  logic [6:0]  hex4_n;
  logic [6:0]  hex5_n;
  logic        update_pulse;
  logic        holding;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state; m_n is the number of clock edges since reset release.
  int          m_n;
  logic [15:0] m_seg;
  logic        m_hold;
  int          m_cnt;
  int          m_bright;
  logic [6:0]  m_hex4, m_hex5;
  logic        m_pulse;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  hex_pair_display_driver #(
    .BLINK_HALF_CYCLES(BLINK),
    .PWM_DIV          (PWMD),
    .HOLD_CYCLES      (HOLD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_in      (seg_in),
    .blink_en    (blink_en),
    .brightness  (brightness),
    .hex4_n      (hex4_n),
    .hex5_n      (hex5_n),
    .update_pulse(update_pulse),
    .holding     (holding)
  );

  task automatic model_reset();
    m_n      = 0;
    m_seg    = 16'hFFFF;
    m_hold   = 1'b0;
    m_cnt    = 0;
    m_bright = 0;
    m_hex4   = 7'h7F;
    m_hex5   = 7'h7F;
    m_pulse  = 1'b0;
    sb.delete();
  endtask

  // Predict the pins after the coming edge and push them to the scoreboard.
  task automatic model_edge();
    int   ph;
    int   pc;
    logic pon, v4, v5, chg;
    ph  = (m_n / BLINK) % 2;
    pc  = (m_n / PWMD) % 16;
    pon = (m_bright == 15) || (pc < m_bright);
    v4  = m_hold || (pon && !(blink_en[0] && (ph == 1)));
    v5  = m_hold || (pon && !(blink_en[1] && (ph == 1)));
    m_hex4  = v4 ? m_seg[6:0]  : 7'h7F;
    m_hex5  = v5 ? m_seg[14:8] : 7'h7F;
    chg     = ({seg_in[14:8], seg_in[6:0]} != {m_seg[14:8], m_seg[6:0]});
    m_pulse = chg;
    if (chg) begin
      m_hold = 1'b1;
      m_cnt  = 0;
    end else if (m_hold) begin
      if (m_cnt == HOLD - 1) begin
        m_hold = 1'b0;
        m_cnt  = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    m_seg = seg_in;
    m_n   = m_n + 1;
    if ((m_n % PERIOD) == 0) m_bright = int'(brightness);
    sb.push_back({m_pulse, m_hold, m_hex5, m_hex4});
  endtask

  // One clock: predict, clock, then pop the prediction beside the observed pins.
  task automatic advance(output logic [15:0] exp_v, output logic [15:0] obs_v);
    model_edge();
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    obs_v = {update_pulse, holding, hex5_n, hex4_n};
  endtask

  task automatic test_reset();
    logic [15:0] e, o;
    reset_n    = 1'b0;
    seg_in     = 16'h4079;
    blink_en   = 2'b01;
    brightness = 4'd15;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({hex5_n, hex4_n, update_pulse, holding} !== {7'h7F, 7'h7F, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state got %h/%h/%b/%b want 7f/7f/0/0", hex5_n, hex4_n, update_pulse, holding);
    end
    @(negedge clk);
    reset_n = 1'b1;
    advance(e, o);
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_edge1 got %h want %h", o, e);
    end
    n_vec++;
    if ({update_pulse, holding, hex4_n} !== {1'b1, 1'b1, 7'h7F}) begin
      n_err++;
      $display("FAIL first_change got pulse=%b hold=%b hex4=%h want 1 1 7f", update_pulse, holding, hex4_n);
    end
    advance(e, o);
    n_vec++;
    if ({update_pulse, hex5_n, hex4_n} !== {1'b0, 7'h40, 7'h79}) begin
      n_err++;
      $display("FAIL latency2 got pulse=%b hex5=%h hex4=%h want 0 40 79", update_pulse, hex5_n, hex4_n);
    end
  endtask

  task automatic test_hold_blink();
    logic [15:0] e, o;
    int hold_n, b4, b5;
    hold_n = 2;
    b4 = 0;
    b5 = 0;
    while (m_n < 104) begin
      advance(e, o);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL hold_blink edge %0d got %h want %h", m_n, o, e);
      end
      if (holding) hold_n++;
      if (m_n >= 41) begin
        if (hex4_n == 7'h7F) b4++;
        if (hex5_n == 7'h7F) b5++;
      end
    end
    n_vec++;
    if (hold_n !== HOLD) begin
      n_err++;
      $display("FAIL hold_length got %0d want %0d", hold_n, HOLD);
    end
    n_vec++;
    if (b4 !== 32) begin
      n_err++;
      $display("FAIL blink_hex4_blank got %0d want 32", b4);
    end
    n_vec++;
    if (b5 !== 0) begin
      n_err++;
      $display("FAIL noblink_hex5_blank got %0d want 0", b5);
    end
  endtask

  task automatic test_pwm();
    logic [15:0] e, o;
    int v4, v5;
    blink_en   = 2'b00;
    brightness = 4'd4;
    do begin
      advance(e, o);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL pwm_align got %h want %h", o, e);
      end
    end while ((m_n % PERIOD) != 0);
    for (int pass = 0; pass < 3; pass++) begin
      v4 = 0;
      v5 = 0;
      if (pass == 1) brightness = 4'd0;
      for (int i = 0; i < PERIOD; i++) begin
        advance(e, o);
        n_vec++;
        if (o !== e) begin
          n_err++;
          $display("FAIL pwm_cycle edge %0d got %h want %h", m_n, o, e);
        end
        if (hex4_n != 7'h7F) v4++;
        if (hex5_n != 7'h7F) v5++;
      end
      if (pass != 1) begin
        n_vec++;
        if ({v4, v5} !== ((pass == 0) ? {32'd8, 32'd8} : {32'd0, 32'd0})) begin
          n_err++;
          $display("FAIL pwm_duty pass %0d got %0d/%0d want %0d", pass, v4, v5, (pass == 0) ? 8 : 0);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    logic [15:0] e, o;
    int v4;
    brightness = 4'd4;
    do begin
      advance(e, o);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL midchg_align got %h want %h", o, e);
      end
    end while ((m_n % PERIOD) != 0);
    for (int p = 0; p < 2; p++) begin
      v4 = 0;
      for (int i = 0; i < PERIOD; i++) begin
        if (p == 0 && i == 16) brightness = 4'd12;
        advance(e, o);
        n_vec++;
        if (o !== e) begin
          n_err++;
          $display("FAIL midchg_cycle edge %0d got %h want %h", m_n, o, e);
        end
        if (hex4_n != 7'h7F) v4++;
      end
      n_vec++;
      if (v4 !== ((p == 0) ? 8 : 24)) begin
        n_err++;
        $display("FAIL midchg_duty period %0d got %0d want %0d", p, v4, (p == 0) ? 8 : 24);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [15:0] e, o;
    int hold_n, pulses, v4;
    brightness = 4'd0;
    blink_en   = 2'b11;
    do begin
      advance(e, o);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL retrig_align got %h want %h", o, e);
      end
    end while ((m_n % PERIOD) != 0);
    hold_n = 0;
    pulses = 0;
    v4 = 0;
    for (int i = 0; i < 45; i++) begin
      if (i == 0)  seg_in = 16'h3F06;
      if (i == 11) seg_in = 16'h5B4F;
      advance(e, o);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL retrig_cycle %0d got %h want %h", i, o, e);
      end
      if (holding) hold_n++;
      if (update_pulse) pulses++;
      if (hex4_n != 7'h7F) v4++;
    end
    n_vec++;
    if ({hold_n, pulses, v4} !== {32'd31, 32'd2, 32'd31}) begin
      n_err++;
      $display("FAIL retrig_summary got hold=%0d pulses=%0d vis=%0d want 31 2 31", hold_n, pulses, v4);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] e, o;
    int hold_n;
    seg_in     = 16'h0000;
    blink_en   = 2'b11;
    brightness = 4'd15;
    repeat (6) begin
      advance(e, o);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL prereset got %h want %h", o, e);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({hex5_n, hex4_n, update_pulse, holding} !== {7'h7F, 7'h7F, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset got %h/%h/%b/%b want 7f/7f/0/0", hex5_n, hex4_n, update_pulse, holding);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    hold_n = 0;
    for (int i = 0; i < 60; i++) begin
      advance(e, o);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL postreset edge %0d got %h want %h", m_n, o, e);
      end
      if (i == 0) begin
        n_vec++;
        if (update_pulse !== 1'b1) begin
          n_err++;
          $display("FAIL postreset_pulse got %b want 1", update_pulse);
        end
      end
      if (holding) hold_n++;
    end
    n_vec++;
    if (hold_n !== HOLD) begin
      n_err++;
      $display("FAIL postreset_hold got %0d want %0d", hold_n, HOLD);
    end
  endtask

  initial begin
    test_reset();
    test_hold_blink();
    test_pwm();
    test_mid_change();
    test_retrigger();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hex_pair_display_driver.md
Name: hex_pair_display_driver

Overview:
- Downstream consumer of the 16-bit HEX5/HEX4 PIO output port.
- Takes the two raw 7-segment patterns that software writes and drives the HEX4/HEX5 pins. Adds per-digit blink, 4-bit PWM brightness and a post-update steady-hold period.
- Sits between the Qsys PIO `out_port` and the top-level HEX pins, in the `clk` domain.

Parameters:
- BLINK_HALF_CYCLES, 12_500_000: clk cycles per blink phase (2 Hz full period at 50 MHz).
- PWM_DIV, 64: clk cycles per PWM step; one PWM period = 16*PWM_DIV cycles.
- HOLD_CYCLES, 25_000_000: cycles the display is held steady at full brightness after a pattern change.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- seg_in  in  16  PIO pattern; [6:0]=HEX4 segs, [14:8]=HEX5 segs, [7],[15] ignored; active-low (0 = lit)
- blink_en  in  2  [0]=blink HEX4, [1]=blink HEX5
- brightness  in  4  duty 0..15; 0=dark, 15=always on
- hex4_n  out  7  HEX4 segment pins, active-low
- hex5_n  out  7  HEX5 segment pins, active-low
- update_pulse  out  1  one-cycle strobe on a detected pattern change
- holding  out  1  high while in HOLD state

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
- Values held in reset:
  - hex4_n = hex5_n = 7'h7F (blank).
  - update_pulse = 0, holding = 0.
  - seg_q = 16'hFFFF; all counters 0; blink_phase = 0 (visible); bright_q = 0; state IDLE.
- Input stage: seg_q <= seg_in every cycle. Only bits [14:8] and [6:0] take part in comparison and output.
- Change detect: update_pulse <= 1 for one cycle when seg_in[14:8,6:0] != seg_q[14:8,6:0].
  - Steady seg_in gives exactly one pulse per change.
  - The first non-FFFF value after reset counts as a change.
- Blink prescaler:
  - blink_cnt counts 0..BLINK_HALF_CYCLES-1 and wraps.
  - On wrap, blink_phase toggles; 1 = blanked phase.
  - Free-running, never reset by updates.
- PWM:
  - pwm_div_cnt counts 0..PWM_DIV-1; on its wrap, pwm_cnt (4-bit) increments and wraps 15 -> 0.
  - bright_q <= brightness only when pwm_cnt wraps to 0 (glitch-free duty change). The new duty takes effect at the next PWM period boundary.
  - pwm_on = (bright_q == 15) | (pwm_cnt < bright_q).
- FSM, 2 states, hold_cnt width = clog2(HOLD_CYCLES):
  - IDLE -> HOLD on a detected change; hold_cnt <= 0.
  - HOLD: hold_cnt increments each cycle. HOLD -> IDLE when hold_cnt == HOLD_CYCLES-1.
  - A change detected while in HOLD restarts hold_cnt at 0 and stays in HOLD (retrigger).
  - holding = (state == HOLD), registered together with the state.
- Output mux, registered, per digit d:
  - vis_d = HOLD ? 1 : (pwm_on & ~(blink_en[d] & blink_phase)).
  - hexd_n <= vis_d ? seg_q[digit bits] : 7'h7F.
- Latency: seg_in -> hex pins = 2 cycles when visible. seg_in -> update_pulse = 1 cycle.
- blink_en changes take effect immediately, on the next output register update; no phase resync.
- Reset asserted mid-HOLD or mid-blink: all state returns to the reset values asynchronously; pins blank at once.

Decomposition:
- Shared package hex_disp_pkg:
  - state enum {IDLE, HOLD}.
  - BLANK7 = 7'h7F.
  - Bit-range constants for HEX4 ([6:0]) and HEX5 ([14:8]).
- One sub-module, hex_pwm_prescaler: blink_cnt, pwm_div_cnt, pwm_cnt, bright_q. Outputs blink_phase and pwm_on.
- FSM, change detect and output mux stay in the top.

Test Plan (BLINK_HALF_CYCLES=8, PWM_DIV=2, HOLD_CYCLES=20):
- Reset check: hold reset_n=0 with seg_in=16'h4079 -> hex4_n=hex5_n=7'h7F, update_pulse=0. Release -> after 1 cycle update_pulse=1 for one cycle, holding=1. 2 cycles after release hex4_n=7'h79, hex5_n=7'h40.
- Hold expiry and blink: seg_in constant, blink_en=2'b01, brightness=15 -> holding drops 20 cycles after entry. hex4_n then alternates 7'h79 / 7'h7F every 8 cycles; hex5_n stays 7'h40.
- PWM duty: brightness=4, no blink, IDLE -> over one 32-cycle PWM period each digit is visible exactly 8 cycles (pwm_cnt 0..3). brightness=0 -> always 7'h7F.
- Mid-period brightness change: set brightness from 4 to 12 mid-period -> current period still shows 8 visible cycles; next period shows 24.
- Hold retrigger: second pattern change at hold_cnt=10 -> update_pulse again, holding stays 1 until 20 cycles after the second change. No blink or PWM blanking during HOLD.
- Mid-operation reset: assert reset_n=0 during HOLD with blink active -> pins go to 7'h7F the same cycle, holding=0. After release the counters restart from 0.
